// File: rtl/csr_pkg.sv
// Shared encodings for the CSR access initiator: Zicsr funct3 values, CSR unit op codes,
// sequencer states and the read-only address check.
package csr_pkg;

    localparam logic [2:0] F3Csrrw  = 3'b001;
    localparam logic [2:0] F3Csrrs  = 3'b010;
    localparam logic [2:0] F3Csrrc  = 3'b011;
    localparam logic [2:0] F3Csrrwi = 3'b101;
    localparam logic [2:0] F3Csrrsi = 3'b110;
    localparam logic [2:0] F3Csrrci = 3'b111;

    typedef enum logic [1:0] {
        CsrOpRw = 2'b00,
        CsrOpRs = 2'b01,
        CsrOpRc = 2'b10
    } csr_op_e;

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StWrite,
        StResp
    } csr_state_e;

    // Addresses with [11:10] == 2'b11 are read-only in the Zicsr address map.
    function automatic logic is_ro(input logic [11:0] addr);
        return addr[11:10] == 2'b11;
    endfunction

endpackage

// File: rtl/csr_req_decode.sv
// Combinational decode of one Zicsr request: CSR op, write operand, whether a write
// happens and whether the instruction is illegal.
module csr_req_decode
    import csr_pkg::*;
#(
    parameter int unsigned CHECK_RO = 1
) (
    input  logic [2:0]  funct3,
    input  logic [11:0] addr,
    input  logic [31:0] rs1,
    input  logic [4:0]  uimm,
    input  logic        src_zero,
    output csr_op_e     op,
    output logic [31:0] operand,
    output logic        do_write,
    output logic        illegal
);

    logic bad_funct3;
    logic wants_write;
    logic ro_hit;

    always_comb begin
        op         = CsrOpRw;
        bad_funct3 = 1'b0;
        unique case (funct3)
            F3Csrrw, F3Csrrwi: op = CsrOpRw;
            F3Csrrs, F3Csrrsi: op = CsrOpRs;
            F3Csrrc, F3Csrrci: op = CsrOpRc;
            default:           bad_funct3 = 1'b1;
        endcase

        operand     = funct3[2] ? {27'd0, uimm} : rs1;
        wants_write = !bad_funct3 && ((op == CsrOpRw) || !src_zero);
        ro_hit      = wants_write && is_ro(addr);
        illegal     = bad_funct3 || ((CHECK_RO != 0) && ro_hit);
        // With CHECK_RO off, a write to a read-only CSR is dropped rather than trapped.
        do_write    = wants_write && !ro_hit;
    end

endmodule

// File: rtl/csr_access_ctrl.sv
// Initiator side of the CSR access interface: accepts one decoded Zicsr request and
// sequences read, optional write and the response back to execute.
module csr_access_ctrl
    import csr_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 0,
    parameter int unsigned CHECK_RO    = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        flush_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [11:0] req_addr_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_rs1_i,
    input  logic [4:0]  req_uimm_i,
    input  logic        req_src_zero_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_illegal_o,
    output logic [11:0] csr_addr_o,
    output logic [31:0] csr_data_o,
    output logic [1:0]  csr_op_o,
    output logic        csr_we_o,
    input  logic [31:0] csr_rdata_i,
    output logic        busy_o
);

    localparam int unsigned CntW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(WAIT_STATES);

    csr_op_e     dec_op;
    logic [31:0] dec_operand;
    logic        dec_do_write;
    logic        dec_illegal;

    csr_req_decode #(
        .CHECK_RO (CHECK_RO)
    ) u_decode (
        .funct3   (req_funct3_i),
        .addr     (req_addr_i),
        .rs1      (req_rs1_i),
        .uimm     (req_uimm_i),
        .src_zero (req_src_zero_i),
        .op       (dec_op),
        .operand  (dec_operand),
        .do_write (dec_do_write),
        .illegal  (dec_illegal)
    );

    csr_state_e      state_q;
    logic [CntW-1:0] cnt_q;
    logic            do_write_q;
    logic            illegal_q;
    logic [31:0]     rdata_q;

    assign busy_o = (state_q != StIdle);

    // The csr_* output registers double as the request latches while READ/WRITE run.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            do_write_q    <= 1'b0;
            illegal_q     <= 1'b0;
            rdata_q       <= '0;
            req_ready_o   <= 1'b1;
            rsp_valid_o   <= 1'b0;
            rsp_rdata_o   <= '0;
            rsp_illegal_o <= 1'b0;
            csr_addr_o    <= '0;
            csr_data_o    <= '0;
            csr_op_o      <= '0;
            csr_we_o      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid_i && !flush_i) begin
                        state_q     <= StRead;
                        req_ready_o <= 1'b0;
                        cnt_q       <= '0;
                        csr_addr_o  <= req_addr_i;
                        csr_data_o  <= dec_operand;
                        csr_op_o    <= dec_op;
                        do_write_q  <= dec_do_write;
                        illegal_q   <= dec_illegal;
                    end
                end
                StRead: begin
                    if (flush_i) begin
                        state_q     <= StIdle;
                        req_ready_o <= 1'b1;
                        cnt_q       <= '0;
                        csr_addr_o  <= '0;
                        csr_data_o  <= '0;
                        csr_op_o    <= '0;
                    end else if (cnt_q == CntMax) begin
                        cnt_q <= '0;
                        if (do_write_q && !illegal_q) begin
                            state_q  <= StWrite;
                            rdata_q  <= csr_rdata_i;
                            csr_we_o <= 1'b1;
                        end else begin
                            state_q       <= StResp;
                            rsp_valid_o   <= 1'b1;
                            rsp_rdata_o   <= illegal_q ? 32'd0 : csr_rdata_i;
                            rsp_illegal_o <= illegal_q;
                            csr_addr_o    <= '0;
                            csr_data_o    <= '0;
                            csr_op_o      <= '0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StWrite: begin
                    csr_we_o   <= 1'b0;
                    csr_addr_o <= '0;
                    csr_data_o <= '0;
                    csr_op_o   <= '0;
                    if (flush_i) begin
                        state_q     <= StIdle;
                        req_ready_o <= 1'b1;
                    end else begin
                        state_q       <= StResp;
                        rsp_valid_o   <= 1'b1;
                        rsp_rdata_o   <= rdata_q;
                        rsp_illegal_o <= 1'b0;
                    end
                end
                StResp: begin
                    if (flush_i || rsp_ready_i) begin
                        state_q       <= StIdle;
                        req_ready_o   <= 1'b1;
                        rsp_valid_o   <= 1'b0;
                        rsp_rdata_o   <= '0;
                        rsp_illegal_o <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
